sd_image_reader: RTL and testbench
==================================

# sd_image_reader

Playback-side SD-card controller: on request, reads the image-index sector to learn how many frames have been saved, then streams one selected frame (SEC_LENGTH consecutive 512-byte sectors) from the card into the 16-bit-write image FIFO. It sits between the SD-card read engine (rd_start_en / rd_sec_addr / rd_busy / rd_data) and the FIFO feeding the DDR/Ethernet path. It is the counterpart of the camera save controller and shares the same sector layout: index at INDEX_SEC_ADDR, image k at k*SEC_LENGTH+1.

## Interface
- SEC_LENGTH, 2000: sectors per image.
- INDEX_SEC_ADDR, 0: sector holding the saved-image count.
- SEC_WORDS, 256: 16-bit words per sector.
- FIFO_DEPTH, 1024: image FIFO depth in words.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sd_init_done  in  1  card initialised; low aborts any operation
- image_read_req  in  1  start request (level or pulse; sampled only in IDLE)
- use_latest  in  1  1: read newest image (count-1); 0: read image_sel
- image_sel  in  16  image index when use_latest=0
- wr_busy  in  1  card busy writing (shared card)
- rd_busy  in  1  card read engine busy
- rd_data_valid  in  1  rd_data qualifier
- rd_data  in  16  read word
- rd_start_en  out  1  one-cycle read start pulse
- rd_sec_addr  out  32  sector address for read
- fifo_wr_level  in  11  current FIFO fill level (words)
- fifo_full  in  1  FIFO full
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  16  FIFO write data
- image_count  out  16  count captured from index sector
- image_read_done  out  1  one-cycle pulse, frame complete
- image_read_err  out  1  one-cycle pulse, request rejected
- fifo_overflow  out  1  sticky: valid word arrived while fifo_full
- o_state  out  3  current state

## Operation
- States: IDLE, IDX_ISSUE, IDX_WAIT, CALC, DAT_ISSUE, DAT_WAIT, DONE.
- card_free = sd_init_done & !rd_busy & !wr_busy.
- IDLE: image_read_req & card_free -> IDX_ISSUE.
- IDX_ISSUE: rd_start_en=1, rd_sec_addr=INDEX_SEC_ADDR -> IDX_WAIT.
- IDX_WAIT: first rd_data_valid word captured into image_count; remaining words discarded (not written to FIFO). On neg_rd_busy -> CALC.
- CALC: idx = use_latest ? image_count-1 : image_sel. If image_count==0 or idx>=image_count: image_read_err pulse -> IDLE. Else base = idx*SEC_LENGTH+1 (32-bit, zero-extended operands), sec_cnt=0 -> DAT_ISSUE.
- DAT_ISSUE: wait until card_free and fifo_wr_level <= FIFO_DEPTH-SEC_WORDS; then rd_start_en=1, rd_sec_addr=base+sec_cnt -> DAT_WAIT.
- DAT_WAIT: fifo_wr_en = rd_data_valid, fifo_wr_data = rd_data (registered, one-cycle latency). If rd_data_valid & fifo_full: fifo_overflow<=1 (word still presented). On neg_rd_busy: if sec_cnt==SEC_LENGTH-1 -> DONE else sec_cnt++ -> DAT_ISSUE.
- DONE: image_read_done pulse -> IDLE.
- sd_init_done low in any state: next cycle IDLE, rd_start_en/fifo_wr_en/pulses 0, sec_cnt 0; no done pulse. fifo_overflow and image_count retain value.
- image_read_req while not IDLE: ignored. fifo_overflow cleared only by reset or entry to IDX_ISSUE.

## Timing
- Reset: all outputs 0, state IDLE, rd_sec_addr 0, image_count 0.
- rd_start_en registered, exactly one cycle per sector; rd_sec_addr valid on that cycle and held until next issue.
- rd_busy double-registered (d0,d1); neg_rd_busy = d1 & !d0, i.e. 2 cycles after rd_busy falls. WAIT states exit only on neg_rd_busy.
- fifo_wr_en/fifo_wr_data lag rd_data_valid/rd_data by 1 cycle; the last data word of a sector is written before the FSM re-issues.
- Minimum gap between sector issues: neg_rd_busy + 1 cycle.
- base multiply may be registered/pipelined within CALC; CALC stays ≤ 3 cycles.

## Structure
- Package sd_img_pkg: SEC_LENGTH, INDEX_SEC_ADDR, SEC_WORDS defaults, state encoding, image_base(idx) function (idx*SEC_LENGTH+1); shared with the save controller.
- Sub-module sd_busy_negedge: 2-flop register + falling-edge detect, reused for rd_busy (and by the writer for wr_busy).

## Test plan
- Index word 3, use_latest=1 -> reads sector 0, then sectors 4001..6000 in order, 2000×256 FIFO writes, one image_read_done.
- Index word 0, request -> sector 0 read only, image_read_err pulse, no FIFO writes, back to IDLE.
- use_latest=0, image_sel=5, index 5 -> image_read_err; image_sel=1 -> first address 2001.
- fifo_wr_level held at 769 -> no rd_start_en; drop to 768 -> issue within 1 cycle; force fifo_full during valid -> fifo_overflow sticky 1.
- wr_busy high at request -> no issue until wr_busy low; sd_init_done dropped mid-sector 10 -> IDLE next cycle, no done, restart reads sector 0 again.
- Request held high across DONE -> new operation starts from IDX_ISSUE; fifo_overflow cleared.

Source files
------------

// File: rtl/sd_img_pkg.sv
// Shared SD-card image layout: sector geometry, reader state encoding and the
// image base-sector helper used by both the save and playback controllers.
package sd_img_pkg;

  localparam int unsigned SEC_LENGTH     = 2000;
  localparam int unsigned INDEX_SEC_ADDR = 0;
  localparam int unsigned SEC_WORDS      = 256;
  localparam int unsigned FIFO_DEPTH     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IDX_ISSUE = 3'd1,
    ST_IDX_WAIT  = 3'd2,
    ST_CALC      = 3'd3,
    ST_DAT_ISSUE = 3'd4,
    ST_DAT_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } rd_state_t;

  // Image k occupies sectors k*SEC_LENGTH+1 onwards; sector 0 is the index.
  function automatic logic [31:0] image_base(input logic [15:0] idx,
                                             input logic [31:0] sec_len = 32'(SEC_LENGTH));
    return {16'd0, idx} * sec_len + 32'd1;
  endfunction

endpackage

// File: rtl/sd_busy_negedge.sv
// Two-flop resynchroniser for a card busy flag with falling-edge detect;
// the fall pulse appears two cycles after the busy input drops.
module sd_busy_negedge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  output logic o_fall
);

  logic r_d0;
  logic r_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0 <= 1'b0;
      r_d1 <= 1'b0;
    end else begin
      r_d0 <= i_busy;
      r_d1 <= r_d0;
    end
  end

  assign o_fall = r_d1 & ~r_d0;

endmodule

// File: rtl/sd_image_reader.sv
// Playback-side SD reader: fetches the saved-image count from the index sector,
// then streams one frame of SEC_LENGTH sectors into the image FIFO.
module sd_image_reader #(
  parameter int unsigned SEC_LENGTH     = sd_img_pkg::SEC_LENGTH,
  parameter int unsigned INDEX_SEC_ADDR = sd_img_pkg::INDEX_SEC_ADDR,
  parameter int unsigned SEC_WORDS      = sd_img_pkg::SEC_WORDS,
  parameter int unsigned FIFO_DEPTH     = sd_img_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        image_read_req,
  input  logic        use_latest,
  input  logic [15:0] image_sel,
  input  logic        wr_busy,
  input  logic        rd_busy,
  input  logic        rd_data_valid,
  input  logic [15:0] rd_data,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  input  logic [10:0] fifo_wr_level,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic [15:0] image_count,
  output logic        image_read_done,
  output logic        image_read_err,
  output logic        fifo_overflow,
  output logic [2:0]  o_state
);

  import sd_img_pkg::*;

  localparam logic [10:0] LVL_MAX  = 11'(FIFO_DEPTH - SEC_WORDS);
  localparam logic [15:0] LAST_SEC = 16'(SEC_LENGTH - 1);

  rd_state_t   r_state;
  rd_state_t   w_next_state;
  logic        w_card_free;
  logic        w_busy_fall;
  logic        w_issue;
  logic [31:0] w_issue_addr;
  logic        w_done;
  logic        w_err;
  logic [15:0] w_idx;
  logic        w_idx_bad;
  logic        w_dat_word;

  logic        r_rd_start_en;
  logic [31:0] r_rd_sec_addr;
  logic        r_fifo_wr_en;
  logic [15:0] r_fifo_wr_data;
  logic [15:0] r_image_count;
  logic        r_first_word;
  logic        r_done;
  logic        r_err;
  logic        r_overflow;
  logic [15:0] r_sec_cnt;
  logic [31:0] r_base;

  assign w_card_free = sd_init_done & ~rd_busy & ~wr_busy;
  assign w_idx       = use_latest ? (r_image_count - 16'd1) : image_sel;
  assign w_idx_bad   = (r_image_count == 16'd0) || (w_idx >= r_image_count);
  assign w_dat_word  = sd_init_done && (r_state == ST_DAT_WAIT) && rd_data_valid;

  sd_busy_negedge u_rd_busy_negedge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_busy (rd_busy),
    .o_fall (w_busy_fall)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the issue/pulse decisions that get registered below
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_rd_sec_addr;
    w_done       = 1'b0;
    w_err        = 1'b0;
    if (!sd_init_done) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (image_read_req && w_card_free) begin
            w_next_state = ST_IDX_ISSUE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_IDX_ISSUE: begin
          w_issue      = 1'b1;
          w_issue_addr = 32'(INDEX_SEC_ADDR);
          w_next_state = ST_IDX_WAIT;
        end
        ST_IDX_WAIT: begin
          if (w_busy_fall) begin
            w_next_state = ST_CALC;
          end else begin
            w_next_state = ST_IDX_WAIT;
          end
        end
        ST_CALC: begin
          if (w_idx_bad) begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_DAT_ISSUE;
          end
        end
        ST_DAT_ISSUE: begin
          // Only start a sector once the FIFO can absorb all of it
          if (w_card_free && (fifo_wr_level <= LVL_MAX)) begin
            w_issue      = 1'b1;
            w_issue_addr = r_base + {16'd0, r_sec_cnt};
            w_next_state = ST_DAT_WAIT;
          end else begin
            w_next_state = ST_DAT_ISSUE;
          end
        end
        ST_DAT_WAIT: begin
          if (w_busy_fall) begin
            if (r_sec_cnt == LAST_SEC) begin
              w_next_state = ST_DONE;
            end else begin
              w_next_state = ST_DAT_ISSUE;
            end
          end else begin
            w_next_state = ST_DAT_WAIT;
          end
        end
        ST_DONE: begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Registered read-engine handshake and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_start_en <= 1'b0;
      r_rd_sec_addr <= 32'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rd_start_en <= w_issue;
      r_done        <= w_done;
      r_err         <= w_err;
      if (w_issue) begin
        r_rd_sec_addr <= w_issue_addr;
      end
    end
  end

  // FIFO write path; overflow is sticky until the next operation starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wr_en   <= 1'b0;
      r_fifo_wr_data <= 16'd0;
      r_overflow     <= 1'b0;
    end else begin
      r_fifo_wr_en <= w_dat_word;
      if (w_dat_word) begin
        r_fifo_wr_data <= rd_data;
      end
      if ((r_state == ST_IDLE) && (w_next_state == ST_IDX_ISSUE)) begin
        r_overflow <= 1'b0;
      end else if (w_dat_word && fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Index capture, frame base and sector counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_image_count <= 16'd0;
      r_first_word  <= 1'b0;
      r_base        <= 32'd0;
      r_sec_cnt     <= 16'd0;
    end else begin
      if (r_state == ST_IDX_ISSUE) begin
        r_first_word <= 1'b1;
      end else if (sd_init_done && (r_state == ST_IDX_WAIT) && rd_data_valid && r_first_word) begin
        r_image_count <= rd_data;
        r_first_word  <= 1'b0;
      end
      if (r_state == ST_CALC) begin
        r_base <= image_base(w_idx, 32'(SEC_LENGTH));
      end
      if (!sd_init_done || (r_state == ST_CALC)) begin
        r_sec_cnt <= 16'd0;
      end else if ((r_state == ST_DAT_WAIT) && w_busy_fall && (r_sec_cnt != LAST_SEC)) begin
        r_sec_cnt <= r_sec_cnt + 16'd1;
      end
    end
  end

  assign rd_start_en     = r_rd_start_en;
  assign rd_sec_addr     = r_rd_sec_addr;
  assign fifo_wr_en      = r_fifo_wr_en;
  assign fifo_wr_data    = r_fifo_wr_data;
  assign image_count     = r_image_count;
  assign image_read_done = r_done;
  assign image_read_err  = r_err;
  assign fifo_overflow   = r_overflow;
  assign o_state         = r_state;

endmodule

// File: tb/tb_sd_image_reader.sv
// Randomised bench for sd_image_reader: a behavioural card/FIFO environment and
// an expected-read-sequence model, checked every cycle.
module tb_sd_image_reader;

  localparam int unsigned TB_SL = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_init_done;
  logic        image_read_req;
  logic        use_latest;
  logic [15:0] image_sel;
  logic        wr_busy;
  logic        rd_busy;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic [10:0] fifo_wr_level;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [15:0] image_count;
  logic        image_read_done;
  logic        image_read_err;
  logic        fifo_overflow;
  logic [2:0]  o_state;

  sd_image_reader #(.SEC_LENGTH(TB_SL)) dut (
    .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done),
    .image_read_req(image_read_req), .use_latest(use_latest), .image_sel(image_sel),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .fifo_wr_level(fifo_wr_level),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .image_count(image_count), .image_read_done(image_read_done),
    .image_read_err(image_read_err), .fifo_overflow(fifo_overflow), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] exp_addr[$];
  logic [31:0] last_addr = 32'd0;
  logic [31:0] first_data_addr = 32'd0;
  logic        next_first = 1'b0;
  int          issue_cnt = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int          exp_done = 0, exp_err = 0, exp_wr_cnt = 0;
  logic        exp_ov = 1'b0;
  logic [15:0] last_cnt = 16'd0;
  logic        checking = 1'b0;

  // environment controls
  logic [15:0] idx_word = 16'd0;
  logic        cur_data = 1'b0;
  logic        lvl_force_en = 1'b0;
  logic [10:0] lvl_force = 11'd0;
  logic        full_force = 1'b0;

  // posedge captures of what the DUT sampled
  logic        s_dv = 1'b0, s_full = 1'b0, s_lvl_ok = 1'b0;
  logic [15:0] s_data = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Card read engine: answers each rd_start_en with a busy window of words
  initial begin
    logic is_idx, aborted;
    int nw, lat, tail;
    rd_busy = 1'b0; rd_data_valid = 1'b0; rd_data = 16'd0;
    forever begin
      @(negedge clk);
      if (rd_start_en === 1'b1) begin
        is_idx   = (rd_sec_addr == 32'd0);
        cur_data = !is_idx;
        nw       = is_idx ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 6));
        lat      = int'($urandom_range(0, 2));
        aborted  = 1'b0;
        repeat (lat) @(negedge clk);
        rd_busy = 1'b1;
        for (int w = 0; w < nw && !aborted; w++) begin
          if ($urandom_range(0, 3) == 0) begin
            rd_data_valid = 1'b0;
            @(negedge clk);
          end
          rd_data_valid = 1'b1;
          rd_data = (is_idx && w == 0) ? idx_word : 16'($urandom);
          @(negedge clk);
          if (!sd_init_done) aborted = 1'b1;
        end
        rd_data_valid = 1'b0;
        tail = int'($urandom_range(0, 2));
        if (!aborted) repeat (tail) @(negedge clk);
        rd_busy  = 1'b0;
        cur_data = 1'b0;
      end
    end
  end

  // FIFO level/full environment
  initial begin
    fifo_wr_level = 11'd0; fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      if (lvl_force_en) fifo_wr_level = lvl_force;
      else if ($urandom_range(0, 3) == 0) fifo_wr_level = 11'($urandom_range(769, 1023));
      else fifo_wr_level = 11'($urandom_range(0, 768));
      fifo_full = full_force ? 1'b1 : ($urandom_range(0, 15) == 0);
    end
  end

  // Capture inputs as the DUT sees them at the active edge
  initial begin
    forever begin
      @(posedge clk);
      s_dv     = rd_data_valid & sd_init_done & cur_data;
      s_full   = fifo_full;
      s_data   = rd_data;
      s_lvl_ok = (fifo_wr_level <= 11'd768) & !rd_busy & !wr_busy & sd_init_done;
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(s_dv));
        if (s_dv) begin
          chk("fifo_wr_data", 32'(fifo_wr_data), 32'(s_data));
          exp_wr_cnt++;
          if (s_full) exp_ov = 1'b1;
        end
        if (fifo_wr_en) wr_cnt++;
        if (rd_start_en) begin
          issue_cnt++;
          if (exp_addr.size() == 0) begin
            chk("unexpected_issue", rd_sec_addr, 32'hFFFF_FFFF);
            last_addr = rd_sec_addr;
          end else begin
            a = exp_addr.pop_front();
            chk("rd_sec_addr", rd_sec_addr, a);
            last_addr = a;
            if (a == 32'd0) begin
              exp_ov = 1'b0;
              next_first = 1'b1;
              chk("ovf_clear_on_start", 32'(fifo_overflow), 32'd0);
            end else begin
              chk("issue_gate", 32'(s_lvl_ok), 32'd1);
              if (next_first) begin
                first_data_addr = rd_sec_addr;
                next_first = 1'b0;
              end
            end
          end
        end else begin
          chk("rd_sec_addr_hold", rd_sec_addr, last_addr);
        end
        if (image_read_done) done_cnt++;
        if (image_read_err) err_cnt++;
      end
    end
  end

  task automatic start_op(input logic [15:0] cnt, input logic ul, input logic [15:0] sel);
    logic [15:0] idx;
    idx_word = cnt; use_latest = ul; image_sel = sel; last_cnt = cnt;
    exp_addr.push_back(32'd0);
    idx = ul ? cnt - 16'd1 : sel;
    if (cnt == 16'd0 || idx >= cnt) begin
      exp_err++;
    end else begin
      for (int i = 0; i < int'(TB_SL); i++) exp_addr.push_back(32'(idx) * TB_SL + 32'd1 + 32'(i));
      exp_done++;
    end
  endtask

  task automatic kick(input int n);
    int b = issue_cnt;
    int c = 0;
    image_read_req = 1'b1;
    while (issue_cnt < b + n && c < 800) begin @(negedge clk); c++; end
    chk("req_accept", 32'(issue_cnt >= b + n), 32'd1);
    image_read_req = 1'b0;
  endtask

  task automatic wait_end();
    int c = 0;
    while ((done_cnt + err_cnt) < (exp_done + exp_err) && c < 3000) begin @(negedge clk); c++; end
    chk("op_complete", 32'((done_cnt + err_cnt) >= (exp_done + exp_err)), 32'd1);
    repeat (4) @(negedge clk);
    chk("pending_issues", 32'(exp_addr.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("err_count", 32'(err_cnt), 32'(exp_err));
    chk("wr_count", 32'(wr_cnt), 32'(exp_wr_cnt));
    chk("image_count", 32'(image_count), 32'(last_cnt));
    chk("state_idle", 32'(o_state), 32'd0);
    chk("ovf_model", 32'(fifo_overflow), 32'(exp_ov));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, i0, w0;
    rst_n = 1'b0; sd_init_done = 1'b1; image_read_req = 1'b0; use_latest = 1'b0;
    image_sel = 16'd0; wr_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_en", 32'(rd_start_en), 32'd0);
    chk("rst_sec_addr", rd_sec_addr, 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_count", 32'(image_count), 32'd0);
    chk("rst_pulses", 32'({image_read_done, image_read_err, fifo_overflow}), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    rst_n = 1'b1; checking = 1'b1;
    repeat (3) @(negedge clk);

    // newest of three images: sectors 13..18
    start_op(16'd3, 1'b1, 16'd0); kick(1); wait_end();
    chk("first_addr_latest3", first_data_addr, 32'd13);

    // empty index and out-of-range selection
    w0 = wr_cnt;
    start_op(16'd0, 1'b1, 16'd0); kick(1); wait_end();
    chk("no_writes_on_err", 32'(wr_cnt - w0), 32'd0);
    start_op(16'd5, 1'b0, 16'd5); kick(1); wait_end();
    start_op(16'd5, 1'b0, 16'd1); kick(1); wait_end();
    chk("first_addr_sel1", first_data_addr, 32'd7);

    // FIFO room gating at 769/768, then forced full sets sticky overflow
    lvl_force_en = 1'b1; lvl_force = 11'd769;
    start_op(16'd2, 1'b1, 16'd0); kick(1);
    c = 0;
    while (o_state != 3'd4 && c < 200) begin @(negedge clk); c++; end
    chk("reach_dat_issue", 32'(o_state), 32'd4);
    i0 = issue_cnt;
    repeat (20) @(negedge clk);
    chk("no_issue_at_769", 32'(issue_cnt), 32'(i0));
    @(posedge clk); lvl_force = 11'd768;
    @(negedge clk); chk("no_issue_before_768", 32'(rd_start_en), 32'd0);
    @(negedge clk); chk("issue_at_768", 32'(rd_start_en), 32'd1);
    lvl_force_en = 1'b0; full_force = 1'b1;
    wait_end();
    chk("ovf_sticky", 32'(fifo_overflow), 32'd1);
    full_force = 1'b0;

    // shared card busy writing blocks the start
    wr_busy = 1'b1;
    start_op(16'd2, 1'b0, 16'd0);
    i0 = issue_cnt; image_read_req = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_issue_wr_busy", 32'(issue_cnt), 32'(i0));
    wr_busy = 1'b0;
    kick(1); wait_end();
    chk("first_addr_sel0", first_data_addr, 32'd1);

    // card drop in the middle of sector 10 aborts without a done pulse
    start_op(16'd2, 1'b1, 16'd0); kick(1);
    c = 0;
    while (last_addr != 32'd10 && c < 800) begin @(negedge clk); c++; end
    chk("reach_sector10", last_addr, 32'd10);
    repeat (2) @(negedge clk);
    sd_init_done = 1'b0;
    exp_addr.delete(); exp_done--;
    @(negedge clk);
    chk("abort_idle", 32'(o_state), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));
    chk("abort_keeps_count", 32'(image_count), 32'd2);
    sd_init_done = 1'b1;
    repeat (3) @(negedge clk);
    start_op(16'd2, 1'b1, 16'd0); kick(1); wait_end();
    chk("restart_first_addr", first_data_addr, 32'd7);

    // request held across DONE restarts from the index read
    start_op(16'd1, 1'b1, 16'd0); start_op(16'd1, 1'b1, 16'd0);
    i0 = issue_cnt; full_force = 1'b1; image_read_req = 1'b1;
    c = 0;
    while (image_read_done !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
    chk("held_first_done", 32'(image_read_done), 32'd1);
    chk("ovf_before_restart", 32'(fifo_overflow), 32'd1);
    full_force = 1'b0;
    c = 0;
    while (issue_cnt < i0 + 8 && c < 200) begin @(negedge clk); c++; end
    chk("held_restart", 32'(issue_cnt >= i0 + 8), 32'd1);
    image_read_req = 1'b0;
    wait_end();

    // randomised operations
    for (int k = 0; k < 10; k++) begin
      start_op(16'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)));
      kick(1); wait_end();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
